// File: rtl/afifo_wptr_gen.sv
// Write-side pointer generator for an async FIFO: binary write pointer, registered
// gray pointer to the read domain, and full/almost_full/level/overflow flags.
module afifo_wptr_gen #(
   parameter int AW    = 4,
   parameter int AF_TH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          srst,
   input  logic          wr_en,
   input  logic [AW:0]   rptr_gray_sync,
   output logic          wr_ack,
   output logic [AW-1:0] waddr,
   output logic [AW:0]   wptr_gray,
   output logic          full,
   output logic          almost_full,
   output logic [AW:0]   level,
   output logic          overflow
);

   localparam int          DEPTH  = 2 ** AW;
   localparam logic [AW:0] AF_LVL = (AW + 1)'(DEPTH - AF_TH);

   logic [AW:0] wbin;
   logic [AW:0] wbin_next;
   logic [AW:0] gray_next;
   logic [AW:0] rbin;
   logic [AW:0] level_next;
   logic [AW:0] full_cmp;
   logic        full_next;
   logic        af_next;

   assign wr_ack = wr_en & ~full & ~srst;
   assign waddr  = wbin[AW-1:0];

   assign wbin_next = wbin + {{AW{1'b0}}, wr_ack};
   assign gray_next = wbin_next ^ (wbin_next >> 1);

   // Each binary bit is the xor of all gray bits at and above it.
   always_comb begin
      rbin = '0;
      for (int i = 0; i <= AW; i++) begin
         rbin[i] = ^(rptr_gray_sync >> i);
      end
   end

   // Full when the write pointer is exactly one lap ahead: top two gray bits inverted.
   assign full_cmp   = {~rptr_gray_sync[AW:AW-1], rptr_gray_sync[AW-2:0]};
   assign full_next  = (gray_next == full_cmp);
   assign level_next = wbin_next - rbin;
   assign af_next    = (level_next >= AF_LVL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbin        <= '0;
         wptr_gray   <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         level       <= '0;
         overflow    <= 1'b0;
      end else if (srst) begin
         wbin        <= '0;
         wptr_gray   <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         level       <= '0;
         overflow    <= 1'b0;
      end else begin
         wbin        <= wbin_next;
         wptr_gray   <= gray_next;
         full        <= full_next;
         almost_full <= af_next;
         level       <= level_next;
         overflow    <= wr_en & full;
      end
   end

endmodule
